car_lane: RTL and testbench

//  One road lane holding NUM_CARS cars that share a direction, speed and sprite type.

---
 rtl/car_lane_pkg.sv | 34 +++
 rtl/car_lane_if.sv | 29 ++
 rtl/car_lane_slot.sv | 60 ++++++
 rtl/car_lane.sv | 113 +++++++++++
 tb/tb_car_lane.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/car_lane_pkg.sv
// Shared lane types, playfield bounds and the spawn-position step used by car_lane.
package car_lane_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        RUN   = 2'd2
    } lane_state_t;

    localparam int unsigned MIN_X          = 100;
    localparam int unsigned MAX_X          = 739;
    localparam int unsigned CAR_WIDTH_DEF  = 48;
    localparam int unsigned CAR_HEIGHT_DEF = 26;

    // Advance a spawn position by one spacing step, folding it back once into
    // the off-screen-inclusive band [MIN_X-width-1, MAX_X+1].
    function automatic logic [9:0] spawn_step(input logic [9:0] pos,
                                              input logic [9:0] spacing,
                                              input logic       face_left,
                                              input int unsigned car_width);
        int p;
        int lo;
        int hi;
        lo = int'(MIN_X) - int'(car_width) - 1;
        hi = int'(MAX_X) + 1;
        p  = face_left ? int'(pos) + int'(spacing) : int'(pos) - int'(spacing);
        if (p < lo)
            p = p + (hi - lo);
        else if (p > hi)
            p = p - (hi - lo);
        return 10'(p);
    endfunction

endpackage

// File: rtl/car_lane_if.sv
// Lane control inputs and per-pixel outputs between the level controller/video path and car_lane.
interface car_lane_if;
    logic       LaneEnable;
    logic       Paused;
    logic       FaceLeft;
    logic [1:0] Type;
    logic [2:0] Speed;
    logic [9:0] Spacing;
    logic [9:0] SpawnX;
    logic [9:0] LaneY;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       CarPixel;
    logic       CarPriority;
    logic [3:0] Tile;
    logic [5:0] PixelX;
    logic [4:0] PixelY;
    logic       Running;

    modport master (
        output LaneEnable, Paused, FaceLeft, Type, Speed, Spacing, SpawnX, LaneY, DrawX, DrawY,
        input  CarPixel, CarPriority, Tile, PixelX, PixelY, Running
    );

    modport slave (
        input  LaneEnable, Paused, FaceLeft, Type, Speed, Spacing, SpawnX, LaneY, DrawX, DrawY,
        output CarPixel, CarPriority, Tile, PixelX, PixelY, Running
    );
endinterface

// File: rtl/car_lane_slot.sv
// One car: X register with move/wrap, horizontal hit test and local sprite column.
module car_slot
    import car_lane_pkg::*;
#(
    parameter int unsigned CAR_WIDTH = CAR_WIDTH_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [9:0] i_load_x,
    input  logic       i_move,
    input  logic       i_face_left,
    input  logic [2:0] i_speed,
    input  logic [9:0] i_draw_x,
    input  logic       i_row_hit,
    output logic       o_hit,
    output logic [5:0] o_pixel_x
);
    logic        r_active;
    logic [9:0]  r_x;
    logic [10:0] w_x11;
    logic [9:0]  w_moved;
    logic [5:0]  w_dx;
    logic        w_col_hit;

    // Wrap tests look at the pre-move position and replace the move outright.
    always_comb begin
        w_x11 = {1'b0, r_x};
        if (i_face_left) begin
            if (w_x11 + 11'(CAR_WIDTH) < 11'(MIN_X))
                w_moved = 10'(MAX_X + 1);
            else
                w_moved = 10'(w_x11 - {8'd0, i_speed});
        end else begin
            if (w_x11 >= 11'(MAX_X))
                w_moved = 10'(MIN_X - CAR_WIDTH - 1);
            else
                w_moved = 10'(w_x11 + {8'd0, i_speed});
        end
        w_dx      = 6'(i_draw_x - r_x);
        w_col_hit = ({1'b0, i_draw_x} >= w_x11) && ({1'b0, i_draw_x} < w_x11 + 11'(CAR_WIDTH));
        o_hit     = r_active && w_col_hit && i_row_hit;
        o_pixel_x = '0;
        if (o_hit)
            o_pixel_x = i_face_left ? w_dx : 6'(CAR_WIDTH - 1) - w_dx;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_active <= 1'b0;
            r_x      <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_x      <= i_load_x;
        end else if (i_move && r_active) begin
            r_x <= w_moved;
        end
    end
endmodule

// File: rtl/car_lane.sv
// One road lane: spawn/run FSM, shared tile animation and lowest-index priority over car slots.
module car_lane
    import car_lane_pkg::*;
#(
    parameter int unsigned NUM_CARS        = 4,
    parameter int unsigned CAR_WIDTH       = CAR_WIDTH_DEF,
    parameter int unsigned CAR_HEIGHT      = CAR_HEIGHT_DEF,
    parameter int unsigned PRIORITY_ROWS   = 10,
    parameter int unsigned TILES_PER_ANIM  = 4,
    parameter int unsigned FRAMES_PER_TILE = 5
) (
    input  logic       FrameClk,
    input  logic       ResetN,
    car_lane_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(NUM_CARS + 1);
    localparam int unsigned FRM_W  = $clog2(FRAMES_PER_TILE + 1);
    localparam int unsigned TILE_W = (TILES_PER_ANIM > 1) ? $clog2(TILES_PER_ANIM) : 1;

    lane_state_t       r_state;
    logic [IDX_W-1:0]  r_spawn_idx;
    logic [9:0]        r_spawn_pos;
    logic [FRM_W-1:0]  r_frame;
    logic [TILE_W-1:0] r_tile;

    logic [9:0]        w_spawn_x;
    logic              w_placing;
    logic              w_run_step;
    logic              w_row_hit;
    logic [9:0]        w_dy;
    logic [NUM_CARS-1:0] w_hit;
    logic [5:0]        w_px [NUM_CARS];
    logic              w_car_pixel;
    logic [5:0]        w_pixel_x;

    // Car 0 takes SpawnX directly; later cars use the accumulated position.
    assign w_spawn_x  = (r_spawn_idx == '0) ? bus.SpawnX : r_spawn_pos;
    assign w_placing  = (r_state == SPAWN) && (r_spawn_idx < IDX_W'(NUM_CARS));
    assign w_run_step = (r_state == RUN) && !bus.Paused;
    assign w_dy       = bus.DrawY - bus.LaneY;
    assign w_row_hit  = ({1'b0, bus.DrawY} >= {1'b0, bus.LaneY}) &&
                        ({1'b0, bus.DrawY} <  {1'b0, bus.LaneY} + 11'(CAR_HEIGHT));

    always_ff @(posedge FrameClk) begin
        if (!ResetN || !bus.LaneEnable) begin
            r_state     <= IDLE;
            r_spawn_idx <= '0;
            r_spawn_pos <= '0;
            r_frame     <= '0;
            r_tile      <= '0;
        end else begin
            case (r_state)
                IDLE:  r_state <= SPAWN;
                SPAWN: begin
                    if (w_placing) begin
                        r_spawn_idx <= r_spawn_idx + 1'b1;
                        r_spawn_pos <= spawn_step(w_spawn_x, bus.Spacing, bus.FaceLeft, CAR_WIDTH);
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.Paused) begin
                        if (r_frame == FRM_W'(FRAMES_PER_TILE)) begin
                            r_frame <= '0;
                            r_tile  <= (r_tile == TILE_W'(TILES_PER_ANIM - 1)) ? '0 : r_tile + 1'b1;
                        end else begin
                            r_frame <= r_frame + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CARS; k++) begin : g_slot
        car_slot #(
            .CAR_WIDTH (CAR_WIDTH)
        ) u_slot (
            .i_clk       (FrameClk),
            .i_rst_n     (ResetN),
            .i_clear     (!bus.LaneEnable),
            .i_load      (w_placing && (r_spawn_idx == IDX_W'(k))),
            .i_load_x    (w_spawn_x),
            .i_move      (w_run_step),
            .i_face_left (bus.FaceLeft),
            .i_speed     (bus.Speed),
            .i_draw_x    (bus.DrawX),
            .i_row_hit   (w_row_hit),
            .o_hit       (w_hit[k]),
            .o_pixel_x   (w_px[k])
        );
    end

    always_comb begin
        w_car_pixel = 1'b0;
        w_pixel_x   = '0;
        for (int unsigned k = 0; k < NUM_CARS; k++) begin
            if (w_hit[k] && !w_car_pixel) begin
                w_car_pixel = 1'b1;
                w_pixel_x   = w_px[k];
            end
        end
    end

    assign bus.CarPixel    = w_car_pixel;
    assign bus.CarPriority = w_car_pixel && (w_dy < 10'(PRIORITY_ROWS));
    assign bus.PixelX      = w_pixel_x;
    assign bus.PixelY      = w_dy[4:0];
    assign bus.Tile        = 4'(int'(bus.Type) * int'(TILES_PER_ANIM) + int'(r_tile));
    assign bus.Running     = (r_state == RUN);
endmodule

// File: tb/tb_car_lane.sv
// Self-checking bench for car_lane: directed vectors, wrap/spawn sequences and a randomized run vs a lane model.
module tb_car_lane;
    localparam int N    = 4;
    localparam int W    = 48;
    localparam int H    = 26;
    localparam int PR   = 10;
    localparam int LO   = 51;
    localparam int HI   = 740;
    localparam int SPAN = 689;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    car_lane_if bus();

    car_lane #(
        .NUM_CARS (N)
    ) dut (
        .FrameClk (clk),
        .ResetN   (rst_n),
        .bus      (bus)
    );

    always #100 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Lane model: cars as a list of positions, animation as a count of animated frames.
    int m_mode;
    int m_placed;
    int m_anim;
    int m_x [N];
    bit m_act [N];

    typedef struct {
        int dx; int dy; int pix; int pri; int px; int py;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int spawn_pos(input int k);
        int p;
        p = int'(bus.SpawnX);
        for (int i = 0; i < k; i++) begin
            p = bus.FaceLeft ? p + int'(bus.Spacing) : p - int'(bus.Spacing);
            if (p < LO) p = p + SPAN;
            else if (p > HI) p = p - SPAN;
        end
        return p;
    endfunction

    task automatic model_clear();
        m_mode = 0; m_placed = 0; m_anim = 0;
        for (int k = 0; k < N; k++) begin m_x[k] = 0; m_act[k] = 0; end
    endtask

    task automatic model_edge();
        if (!rst_n || !bus.LaneEnable) begin
            model_clear();
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_placed < N) begin
                m_x[m_placed] = spawn_pos(m_placed);
                m_act[m_placed] = 1;
                m_placed++;
            end else begin
                m_mode = 2;
            end
        end else if (!bus.Paused) begin
            m_anim++;
            for (int k = 0; k < N; k++) begin
                if (m_act[k]) begin
                    if (bus.FaceLeft)
                        m_x[k] = (m_x[k] + W < 100) ? 740 : m_x[k] - int'(bus.Speed);
                    else
                        m_x[k] = (m_x[k] >= 739) ? 51 : m_x[k] + int'(bus.Speed);
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int dx, input int dy);
        int pix, pri, px, rel;
        bus.DrawX = 10'(dx);
        bus.DrawY = 10'(dy);
        #1;
        pix = 0; px = 0;
        rel = dy - int'(bus.LaneY);
        for (int k = 0; k < N; k++) begin
            if (pix == 0 && m_act[k] && dx >= m_x[k] && dx < m_x[k] + W && rel >= 0 && rel < H) begin
                pix = 1;
                px  = bus.FaceLeft ? dx - m_x[k] : W - 1 - (dx - m_x[k]);
            end
        end
        pri = (pix == 1 && rel < PR) ? 1 : 0;
        check($sformatf("CarPixel@%0d,%0d", dx, dy), int'(bus.CarPixel), pix);
        check($sformatf("CarPriority@%0d,%0d", dx, dy), int'(bus.CarPriority), pri);
        check($sformatf("PixelX@%0d,%0d", dx, dy), int'(bus.PixelX), px);
        check($sformatf("PixelY@%0d,%0d", dx, dy), int'(bus.PixelY), rel & 31);
    endtask

    task automatic check_frame();
        int dy;
        check("Running", int'(bus.Running), (m_mode == 2) ? 1 : 0);
        check("Tile", int'(bus.Tile), int'(bus.Type) * 4 + (m_anim / 6) % 4);
        for (int k = 0; k < N; k++) begin
            if (m_act[k]) begin
                dy = int'(bus.LaneY) + $urandom_range(0, H - 1);
                if (m_x[k] >= 1) probe(m_x[k] - 1, dy);
                probe(m_x[k], dy);
                probe(m_x[k] + W - 1, dy);
                if (m_x[k] + W <= 1023) probe(m_x[k] + W, dy);
            end
        end
        dy = int'(bus.LaneY) + $urandom_range(0, H + 5) - 3;
        if (dy < 0) dy = 0;
        probe($urandom_range(0, 1023), dy);
    endtask

    task automatic set_lane(input int sx, input int spc, input int fl, input int spd);
        bus.SpawnX = 10'(sx); bus.Spacing = 10'(spc);
        bus.FaceLeft = fl[0]; bus.Speed = 3'(spd);
    endtask

    task automatic restart_to_run();
        bus.LaneEnable = 1'b0;
        tick();
        bus.LaneEnable = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); check_frame(); end
    endtask

    vec_t vecs [12];
    int   lat;
    int   held_tile;

    initial begin
        model_clear();
        bus.LaneEnable = 1'b1; bus.Paused = 1'b0; bus.Type = 2'd2;
        bus.LaneY = 10'd100; bus.DrawX = '0; bus.DrawY = '0;
        set_lane(300, 160, 0, 0);

        // Reset held two frames with the lane enabled.
        rst_n = 1'b0;
        tick(); tick();
        check("rst_Running", int'(bus.Running), 0);
        check("rst_Tile", int'(bus.Tile), 8);
        probe(300, 100);
        check_frame();

        // Spawn into RUN and measure the latency from reset release.
        bus.Type = 2'd1;
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            check_frame();
            if (bus.Running) lat = i;
        end
        check("run_latency", lat, 6);

        // Cars at 300, 140, 669 (wrapped), 509 facing right, standing still.
        vecs[0]  = '{300, 100, 1, 1, 47, 0};
        vecs[1]  = '{347, 100, 1, 1, 0, 0};
        vecs[2]  = '{348, 100, 0, 0, 0, 0};
        vecs[3]  = '{299, 100, 0, 0, 0, 0};
        vecs[4]  = '{300, 110, 1, 0, 47, 10};
        vecs[5]  = '{300, 125, 1, 0, 47, 25};
        vecs[6]  = '{300, 126, 0, 0, 0, 26};
        vecs[7]  = '{300, 99,  0, 0, 0, 31};
        vecs[8]  = '{140, 109, 1, 1, 47, 9};
        vecs[9]  = '{187, 105, 1, 1, 0, 5};
        vecs[10] = '{679, 100, 1, 1, 37, 0};
        vecs[11] = '{509, 120, 1, 0, 47, 20};
        for (int i = 0; i < 12; i++) begin
            bus.DrawX = 10'(vecs[i].dx);
            bus.DrawY = 10'(vecs[i].dy);
            #1;
            check($sformatf("vec%0d_CarPixel", i), int'(bus.CarPixel), vecs[i].pix);
            check($sformatf("vec%0d_CarPriority", i), int'(bus.CarPriority), vecs[i].pri);
            check($sformatf("vec%0d_PixelX", i), int'(bus.PixelX), vecs[i].px);
            check($sformatf("vec%0d_PixelY", i), int'(bus.PixelY), vecs[i].py);
        end

        // Animation over 24 RUN frames, then a pause.
        bus.Type = 2'd0;
        restart_to_run();
        check("anim_tile_0", int'(bus.Tile), 0);
        for (int j = 1; j <= 24; j++) begin
            tick();
            check($sformatf("anim_tile_%0d", j), int'(bus.Tile), (j / 6) % 4);
        end
        bus.Paused = 1'b1; bus.Speed = 3'd5;
        held_tile = int'(bus.Tile);
        for (int j = 0; j < 5; j++) begin
            tick();
            check_frame();
            check("pause_tile", int'(bus.Tile), held_tile);
        end
        probe(300, 100);
        bus.Paused = 1'b0;

        // Right wrap: 738 -> 741 -> 51.
        set_lane(738, 200, 0, 3);
        restart_to_run();
        tick(); check_frame();
        probe(741, 100);
        check("rwrap_741", int'(bus.PixelX), 47);
        tick(); check_frame();
        probe(51, 100);
        check("rwrap_51_px", int'(bus.PixelX), 47);
        probe(50, 100);
        check("rwrap_50_miss", int'(bus.CarPixel), 0);

        // Left wrap: 50 -> 740.
        set_lane(50, 200, 1, 2);
        restart_to_run();
        tick(); check_frame();
        probe(740, 100);
        check("lwrap_740_hit", int'(bus.CarPixel), 1);
        check("lwrap_740_px", int'(bus.PixelX), 0);

        // Overlapping cars: lowest index supplies PixelX.
        set_lane(300, 20, 1, 0);
        restart_to_run();
        probe(330, 100);
        check("overlap_px", int'(bus.PixelX), 30);

        // Enable dropped after two cars placed, then a fresh spawn from SpawnX.
        set_lane(400, 100, 0, 1);
        bus.LaneEnable = 1'b0; tick();
        bus.LaneEnable = 1'b1;
        tick(); tick(); tick(); check_frame();
        probe(300, 100);
        check("midspawn_car1", int'(bus.CarPixel), 1);
        bus.LaneEnable = 1'b0; tick(); check_frame();
        probe(400, 100);
        check("drop_car0_gone", int'(bus.CarPixel), 0);
        check("drop_running", int'(bus.Running), 0);
        bus.LaneEnable = 1'b1;
        tick(); tick(); check_frame();
        probe(400, 100);
        check("respawn_car0_px", int'(bus.PixelX), 47);
        probe(300, 100);
        check("respawn_car1_absent", int'(bus.CarPixel), 0);

        // Randomized traffic against the model.
        for (int f = 0; f < 400; f++) begin
            if (m_mode == 2 && $urandom_range(0, 7) == 0)
                set_lane($urandom_range(LO, HI), $urandom_range(0, SPAN), $urandom_range(0, 1),
                         $urandom_range(0, 7));
            bus.Speed      = 3'($urandom_range(0, 7));
            bus.Type       = 2'($urandom_range(0, 3));
            bus.Paused     = ($urandom_range(0, 4) == 0);
            bus.LaneEnable = ($urandom_range(0, 29) != 0);
            rst_n          = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 19) == 0) bus.LaneY = 10'($urandom_range(0, 990));
            tick();
            check_frame();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
